// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the 5-stage PA-RISC pipeline: tracks in-flight destinations, forwards,
// stalls on load-use and squashes after taken branches, with saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_ra,
  input  logic [4:0]       id_rb,
  input  logic             id_ra_use,
  input  logic             id_rb_use,
  input  logic [4:0]       id_rd,
  input  logic             id_rf_le,
  input  logic             id_l,
  input  logic             br_taken,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             nop_s,
  output logic             ta_s,
  output logic [1:0]       a_s,
  output logic [1:0]       b_s,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Remaining squash cycles after the branch cycle itself; never exceeds FLUSH_CYCLES-1.
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } slot_t;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [FC_W-1:0] flush_left, flush_left_nxt;
  slot_t           ex_slot, mem_slot, wb_slot;
  logic            stall_inc, flush_inc;
  logic            load_use;

  function automatic logic slot_hit(input slot_t s, input logic [4:0] src, input logic src_use);
    return s.we && (s.rd != 5'd0) && (s.rd == src) && src_use;
  endfunction

  function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem, input slot_t wb,
                                         input logic [4:0] src, input logic src_use);
    if (slot_hit(ex, src, src_use))       return 2'b01;
    else if (slot_hit(mem, src, src_use)) return 2'b10;
    else if (slot_hit(wb, src, src_use))  return 2'b11;
    else                                  return 2'b00;
  endfunction

  assign a_s = fwd_sel(ex_slot, mem_slot, wb_slot, id_ra, id_ra_use);
  assign b_s = fwd_sel(ex_slot, mem_slot, wb_slot, id_rb, id_rb_use);

  // The load result only exists once the load reaches MEM, so a consumer right behind it must wait.
  assign load_use = ex_slot.ld &&
                    (slot_hit(ex_slot, id_ra, id_ra_use) || slot_hit(ex_slot, id_rb, id_rb_use));

  // NOTE: every output of a combinational block gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to remember the old value.
  always_comb begin
    state_nxt      = state;
    flush_left_nxt = flush_left;
    pc_le          = 1'b1;
    ifid_le        = 1'b1;
    nop_s          = 1'b0;
    ta_s           = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    unique case (state)
      RUN: begin
        if (br_taken) begin
          ta_s      = 1'b1;
          nop_s     = 1'b1;
          flush_inc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt      = FLUSH;
            flush_left_nxt = FLUSH_RELOAD;
          end
        end else if (load_use) begin
          pc_le     = 1'b0;
          ifid_le   = 1'b0;
          nop_s     = 1'b1;
          stall_inc = 1'b1;
        end
      end
      FLUSH: begin
        // EX holds only bubbles here, so neither a branch nor a load-use can be live.
        nop_s          = 1'b1;
        flush_inc      = 1'b1;
        flush_left_nxt = flush_left - FC_W'(1);
        if (flush_left == FC_W'(1)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge value of the others, exactly like the hardware flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_left <= '0;
      ex_slot    <= '0;
      mem_slot   <= '0;
      wb_slot    <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      flush_left <= flush_left_nxt;
      wb_slot    <= mem_slot;
      mem_slot   <= ex_slot;
      ex_slot    <= nop_s ? slot_t'('0) : slot_t'{rd: id_rd, we: id_rf_le, ld: id_l};
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
